// File: rtl/shift_issue_stage.sv
// ---------------------------------------------------------------------------
// shift_issue_stage
//
// Single-issue shift execution stage with a valid/ready handshake on both
// sides. Each accepted op is shifted combinationally and the result is
// registered, so it appears one cycle after acceptance.
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   in_valid/ready  : upstream handshake
//   in_op           : 00 SLL, 01 SRL, 11 SRA, 10 PASS
//   in_rs1          : value to shift
//   in_rs2          : register shift source, only [4:0] used
//   in_imm          : immediate shift amount
//   in_use_imm      : 1 selects in_imm, 0 selects in_rs2[4:0]
//   in_rd           : destination tag, carried through unchanged
//   out_valid/ready : downstream handshake
//   out_result      : shifted value
//   out_rd          : tag paired with out_result
//
// Configuration
//   SHIFT_SKID_EN : when defined, a 2-entry FIFO skid buffer with a registered
//                   in_ready; otherwise a single output register with
//                   in_ready = !out_valid || out_ready.
// ---------------------------------------------------------------------------

// Right-only logarithmic shifter: five stages of 1/2/4/8/16 positions.
module chainshifter (
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  input  logic        arith,
  output logic [31:0] data_out
);

  logic [5:0][31:0] stage;
  logic             fill;

  assign fill     = arith & data_in[31];
  assign stage[0] = data_in;

  for (genvar i = 0; i < 5; i++) begin : g_stage
    localparam int S = 1 << i;
    assign stage[i+1] = shamt[i] ? {{S{fill}}, stage[i][31:S]} : stage[i];
  end

  assign data_out = stage[5];

endmodule

module shift_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [4:0]  in_imm,
  input  logic        in_use_imm,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd
);

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_PASS = 2'b10;
  localparam logic [1:0] OP_SRA  = 2'b11;

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  logic [4:0]  shamt;
  logic [31:0] sh_in;
  logic [31:0] sh_out;
  logic [31:0] result;
  logic        is_sra;
  logic        in_fire;
  logic        out_fire;
  logic [26:0] rs2_unused;

  // Upper rs2 bits never influence the shift amount.
  assign rs2_unused = in_rs2[31:5];

  // Left shifts reuse the right shifter by mirroring the operand in and out.
  always_comb begin
    shamt  = in_use_imm ? in_imm : in_rs2[4:0];
    sh_in  = (in_op == OP_SLL) ? bitrev(in_rs1) : in_rs1;
    is_sra = (in_op == OP_SRA);
  end

  chainshifter u_shifter (
    .data_in  (sh_in),
    .shamt    (shamt),
    .arith    (is_sra),
    .data_out (sh_out)
  );

  // Final result select; PASS ignores the shift amount entirely.
  always_comb begin
    result = in_rs1;
    case (in_op)
      OP_SLL:  result = bitrev(sh_out);
      OP_SRL:  result = sh_out;
      OP_SRA:  result = sh_out;
      default: result = in_rs1;
    endcase
  end

  assign out_fire = out_valid & out_ready;

`ifdef SHIFT_SKID_EN

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

  occ_t        state_q;
  occ_t        state_d;
  logic        not_full_q;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [31:0] mem_result [2];
  logic [4:0]  mem_rd     [2];

  // not_full_q is a pure register; rst only masks it so nothing is taken
  // while the stage is being reset.
  assign in_ready   = not_full_q & ~rst;
  assign in_fire    = in_valid & in_ready;
  assign out_valid  = (state_q != EMPTY);
  assign out_result = mem_result[rd_ptr];
  assign out_rd     = mem_rd[rd_ptr];

  // Occupancy tracking; FULL never sees an input transfer since in_ready is low.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (in_fire) state_d = ONE;
      ONE: begin
        if (in_fire && !out_fire)      state_d = FULL;
        else if (!in_fire && out_fire) state_d = EMPTY;
      end
      FULL:    if (out_fire) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // FIFO storage, pointers, and the registered not-full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= EMPTY;
      not_full_q    <= 1'b1;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      mem_result[0] <= '0;
      mem_result[1] <= '0;
      mem_rd[0]     <= '0;
      mem_rd[1]     <= '0;
    end else begin
      state_q    <= state_d;
      not_full_q <= (state_d != FULL);
      if (in_fire) begin
        mem_result[wr_ptr] <= result;
        mem_rd[wr_ptr]     <= in_rd;
        wr_ptr             <= ~wr_ptr;
      end
      if (out_fire) rd_ptr <= ~rd_ptr;
    end
  end

`else

  assign in_ready = ~rst & (~out_valid | out_ready);
  assign in_fire  = in_valid & in_ready;

  // Single output register; it only reloads when its content is leaving or
  // absent, so a stalled result holds steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
    end else if (in_fire) begin
      out_valid  <= 1'b1;
      out_result <= result;
      out_rd     <= in_rd;
    end else if (out_fire) begin
      out_valid  <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_shift_issue_stage
//
// Self-checking bench for shift_issue_stage. Accepted ops are turned into
// expected results by an arithmetic reference model and queued; a negedge
// monitor pops and compares whenever a result leaves the stage.
// ---------------------------------------------------------------------------
module tb_shift_issue_stage;

`ifdef SHIFT_SKID_EN
  localparam int BP_ACCEPT = 2;
`else
  localparam int BP_ACCEPT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_imm;
  logic        in_use_imm;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;
  int out_cnt  = 0;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];

  shift_issue_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd)
  );

  always #5 clk = ~clk;

  // Reference behaviour straight from the op definitions.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] rs1,
                                            input logic [31:0] rs2, input logic [4:0] imm,
                                            input logic use_imm);
    int unsigned sh;
    sh = use_imm ? int'(imm) : int'(rs2 % 32);
    case (op)
      2'b00:   return rs1 << sh;
      2'b01:   return rs1 >> sh;
      2'b11:   return 32'($signed(rs1) >>> sh);
      default: return rs1;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Scoreboard monitor: pop/compare on output transfers, push on input transfers.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        out_cnt++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_result actual=%0h required=none", out_result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_output("sb_result", 64'(out_result), 64'(e.result));
          check_output("sb_rd", 64'(out_rd), 64'(e.rd));
        end
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        sb.push_back({ref_shift(in_op, in_rs1, in_rs2, in_imm, in_use_imm), in_rd});
      end
    end
  end

  task automatic randomize_inputs();
    in_op      = 2'($urandom_range(0, 3));
    in_rs1     = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom : $urandom;
    in_rs2     = $urandom;
    in_imm     = 5'($urandom_range(0, 31));
    in_use_imm = 1'($urandom_range(0, 1));
    in_rd      = 5'($urandom_range(0, 31));
  endtask

  // Present one op and hold it until accepted (bounded).
  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [4:0] imm,
                                input logic use_imm, input logic [4:0] rd);
    bit done = 0;
    in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_use_imm = use_imm; in_rd = rd; in_valid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout actual=0 required=1");
    end
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic directed(input string name, input logic [1:0] op, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [4:0] imm, input logic use_imm,
                          input logic [4:0] rd, input logic [31:0] expected);
    out_ready = 1'b0;
    apply_stimulus(op, rs1, rs2, imm, use_imm, rd);
    @(negedge clk);
    check_output({name, "_valid"}, 64'(out_valid), 64'd1);
    check_output({name, "_result"}, 64'(out_result), 64'(expected));
    check_output({name, "_rd"}, 64'(out_rd), 64'(rd));
    drain();
  endtask

  initial begin
    int a0;
    int o0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_use_imm = 1'b0; in_rd = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_out_result", 64'(out_result), 64'd0);
    check_output("rst_out_rd", 64'(out_rd), 64'd0);
    check_output("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("post_rst_in_ready", 64'(in_ready), 64'd1);
    check_output("post_rst_no_x", 64'($isunknown({out_result, out_rd})), 64'd0);
    @(posedge clk); #1;

    // Directed corner vectors.
    directed("sra31", 2'b11, 32'h8000_0000, 32'h0000_001F, 5'd0,  1'b0, 5'd7,  32'hFFFF_FFFF);
    directed("sll_imm", 2'b00, 32'h0000_0001, 32'h0000_0003, 5'd31, 1'b1, 5'd12, 32'h8000_0000);
    directed("srl_rs2", 2'b01, 32'hF000_0000, 32'hFFFF_FFE4, 5'd0,  1'b0, 5'd3,  32'h0F00_0000);
    directed("pass", 2'b10, 32'h1234_5678, 32'h0, 5'd9,  1'b1, 5'd21, 32'h1234_5678);
    directed("sra_zero", 2'b11, 32'h8765_4321, 32'h0, 5'd0, 1'b1, 5'd1, 32'h8765_4321);

    // Backpressure: downstream stalled while upstream keeps offering.
    out_ready = 1'b0;
    a0 = acc_cnt; o0 = out_cnt;
    for (int i = 0; i < 4; i++) begin
      randomize_inputs();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_output("bp_accepted", 64'(acc_cnt - a0), 64'(BP_ACCEPT));
    check_output("bp_in_ready", 64'(in_ready), 64'd0);
    drain();
    check_output("bp_drained", 64'(out_cnt - o0), 64'(BP_ACCEPT));

    // Streaming: one op per cycle in and out.
    out_ready = 1'b1;
    a0 = acc_cnt; o0 = out_cnt;
    for (int i = 0; i < 16; i++) begin
      randomize_inputs();
      in_valid = 1'b1;
      @(negedge clk);
      if (i > 0) check_output("stream_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_output("stream_last_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    check_output("stream_accepted", 64'(acc_cnt - a0), 64'd16);
    check_output("stream_results", 64'(out_cnt - o0), 64'd16);
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    drain();

    // Reset with results pending: nothing stale may come out afterwards.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    check_output("pre_rst_out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_output("in_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_output("mid_rst_out_result", 64'(out_result), 64'd0);
    check_output("mid_rst_out_rd", 64'(out_rd), 64'd0);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_output("after_rst_in_ready", 64'(in_ready), 64'd1);
    check_output("after_rst_out_valid", 64'(out_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_output("no_stale_valid", 64'(out_valid), 64'd0);

    // Traffic after reset must only show fresh results.
    for (int i = 0; i < 60; i++) begin
      randomize_inputs();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
